// File: rtl/register_status_file_if.sv
// Dispatcher/RoB-facing bus of the architectural register status file.
//   master : the dispatcher and RoB side. It drives rename, query and commit
//            and reads back the operand lookups.
//   slave  : the register status file.
// Signals:
//   rename_en/reg/index         : allocate rd to a new RoB entry
//   query_rs1/rs2               : source register lookups
//   rsN_busy/tag/data           : lookup result (tag valid when busy, data when !busy)
//   commit_en/reg/index/data    : RoB commit stream (RF_update_*)
interface register_status_file_if #(
  parameter int RoB_WIDTH = 3
);
  logic                 rename_en;
  logic [4:0]           rename_reg;
  logic [RoB_WIDTH-1:0] rename_index;
  logic [4:0]           query_rs1;
  logic [4:0]           query_rs2;
  logic                 rs1_busy;
  logic [RoB_WIDTH-1:0] rs1_tag;
  logic [31:0]          rs1_data;
  logic                 rs2_busy;
  logic [RoB_WIDTH-1:0] rs2_tag;
  logic [31:0]          rs2_data;
  logic                 commit_en;
  logic [4:0]           commit_reg;
  logic [RoB_WIDTH-1:0] commit_index;
  logic [31:0]          commit_data;

  modport master (
    output rename_en, rename_reg, rename_index, query_rs1, query_rs2,
           commit_en, commit_reg, commit_index, commit_data,
    input  rs1_busy, rs1_tag, rs1_data, rs2_busy, rs2_tag, rs2_data
  );

  modport slave (
    input  rename_en, rename_reg, rename_index, query_rs1, query_rs2,
           commit_en, commit_reg, commit_index, commit_data,
    output rs1_busy, rs1_tag, rs1_data, rs2_busy, rs2_tag, rs2_data
  );
endinterface

// File: rtl/register_status_file.sv
// Architectural register file x0..x31 with per-register rename status.
// Retires the RoB commit stream into architectural state and serves the
// dispatcher with zero-latency operand lookups (value or RoB tag to wait on).
// Ports:
//   clk_in   : clock, all state on rising edge
//   rst_in   : asynchronous active-low reset
//   rdy_in   : global ready, low holds all state
//   flush_in : mispredict flush, clears all rename status
//   bus      : register_status_file_if.slave (rename / query / commit)
// Optional macro RF_DEBUG_PORT_EN adds debug_sel / debug_data /
// debug_commit_cnt (raw data read port and accepted-commit counter).

// One architectural register: value, busy flag, producing RoB tag.
// Write enables arrive already qualified by ready, x0 and register match.
module register_status_file_entry #(
  parameter int RoB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 commit_we,
  input  logic [RoB_WIDTH-1:0] commit_index,
  input  logic [31:0]          commit_data,
  input  logic                 rename_we,
  input  logic [RoB_WIDTH-1:0] rename_index,
  input  logic                 flush_we,
  output logic [31:0]          data_q,
  output logic                 busy_q,
  output logic [RoB_WIDTH-1:0] tag_q
);
  logic [31:0]          data_d;
  logic                 busy_d;
  logic [RoB_WIDTH-1:0] tag_d;

  always_comb begin
    data_d = commit_we ? commit_data : data_q;
    tag_d  = rename_we ? rename_index : tag_q;
    busy_d = busy_q;
    // Priority: a new rename wins over flush/commit. Only the commit that
    // matches the latest rename may clear busy, so a stale commit cannot
    // free a newer mapping.
    if (rename_we)                             busy_d = 1'b1;
    else if (flush_we)                         busy_d = 1'b0;
    else if (commit_we && tag_q == commit_index) busy_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_q <= '0;
      busy_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end
endmodule

module register_status_file #(
  parameter int RoB_WIDTH = 3,
  parameter int REG_COUNT = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  register_status_file_if.slave bus
`ifdef RF_DEBUG_PORT_EN
  ,
  input  logic [4:0]           debug_sel,
  output logic [31:0]          debug_data,
  output logic [31:0]          debug_commit_cnt
`endif
);
  typedef struct packed {
    logic                 busy;
    logic [RoB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } rd_rsp_t;

  logic [REG_COUNT-1:0][31:0]          data_q;
  logic [REG_COUNT-1:0]                busy_q;
  logic [REG_COUNT-1:0][RoB_WIDTH-1:0] tag_q;

  logic commit_acc, rename_acc, flush_acc;

  assign commit_acc = rdy_in && bus.commit_en && (bus.commit_reg != 5'd0);
  assign rename_acc = rdy_in && bus.rename_en && !flush_in && (bus.rename_reg != 5'd0);
  assign flush_acc  = rdy_in && flush_in;

  // x0 has no storage.
  assign data_q[0] = '0;
  assign busy_q[0] = 1'b0;
  assign tag_q[0]  = '0;

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_reg
    register_status_file_entry #(.RoB_WIDTH(RoB_WIDTH)) u_entry (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .commit_we    (commit_acc && bus.commit_reg == 5'(r)),
      .commit_index (bus.commit_index),
      .commit_data  (bus.commit_data),
      .rename_we    (rename_acc && bus.rename_reg == 5'(r)),
      .rename_index (bus.rename_index),
      .flush_we     (flush_acc),
      .data_q       (data_q[r]),
      .busy_q       (busy_q[r]),
      .tag_q        (tag_q[r])
    );
  end

  // Lookup with commit bypass. A same-cycle rename is deliberately ignored:
  // sources are read against the mapping that existed before rd is renamed.
  function automatic rd_rsp_t lookup(input logic [4:0] r);
    rd_rsp_t rsp;
    rsp.busy = busy_q[r];
    rsp.tag  = tag_q[r];
    rsp.data = data_q[r];
    if (r == 5'd0) begin
      rsp = '0;
    end else if (busy_q[r] && bus.commit_en && bus.commit_reg == r &&
                 bus.commit_index == tag_q[r]) begin
      rsp.busy = 1'b0;
      rsp.data = bus.commit_data;
    end
    return rsp;
  endfunction

  rd_rsp_t rs1_rsp, rs2_rsp;

  always_comb begin
    rs1_rsp = lookup(bus.query_rs1);
    rs2_rsp = lookup(bus.query_rs2);
  end

  assign bus.rs1_busy = rs1_rsp.busy;
  assign bus.rs1_tag  = rs1_rsp.tag;
  assign bus.rs1_data = rs1_rsp.data;
  assign bus.rs2_busy = rs2_rsp.busy;
  assign bus.rs2_tag  = rs2_rsp.tag;
  assign bus.rs2_data = rs2_rsp.data;

`ifdef RF_DEBUG_PORT_EN
  logic [31:0] dbg_cnt_q, dbg_cnt_d;

  assign dbg_cnt_d = commit_acc ? dbg_cnt_q + 32'd1 : dbg_cnt_q;

  // Counts retirements, so flush leaves it alone.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) dbg_cnt_q <= '0;
    else         dbg_cnt_q <= dbg_cnt_d;
  end

  assign debug_data       = data_q[debug_sel];
  assign debug_commit_cnt = dbg_cnt_q;
`endif
endmodule

// File: tb/tb_register_status_file.sv
module tb_register_status_file;
  localparam int RW = 3;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush_in;

  register_status_file_if #(.RoB_WIDTH(RW)) bus ();

`ifdef RF_DEBUG_PORT_EN
  logic [4:0]  debug_sel = 5'd0;
  logic [31:0] debug_data, debug_commit_cnt;
`endif

  register_status_file #(.RoB_WIDTH(RW), .REG_COUNT(32)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .bus      (bus.slave)
`ifdef RF_DEBUG_PORT_EN
    ,
    .debug_sel        (debug_sel),
    .debug_data       (debug_data),
    .debug_commit_cnt (debug_commit_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic          rdy, fl;
    logic          ren;  logic [4:0] rreg; logic [RW-1:0] ridx;
    logic          cen;  logic [4:0] creg; logic [RW-1:0] cidx; logic [31:0] cdata;
    logic [4:0]    q1, q2;
    logic          eb1;  logic [RW-1:0] et1; logic [31:0] ed1;
    logic          eb2;  logic [RW-1:0] et2; logic [31:0] ed2;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic rdy, fl, ren, input logic [4:0] rreg,
                             input logic [RW-1:0] ridx, input logic cen,
                             input logic [4:0] creg, input logic [RW-1:0] cidx,
                             input logic [31:0] cdata, input logic [4:0] q1,
                             input logic eb1, input logic [RW-1:0] et1,
                             input logic [31:0] ed1, input logic [4:0] q2,
                             input logic eb2, input logic [RW-1:0] et2,
                             input logic [31:0] ed2);
    vec_t t;
    t.rdy = rdy; t.fl = fl; t.ren = ren; t.rreg = rreg; t.ridx = ridx;
    t.cen = cen; t.creg = creg; t.cidx = cidx; t.cdata = cdata;
    t.q1 = q1; t.eb1 = eb1; t.et1 = et1; t.ed1 = ed1;
    t.q2 = q2; t.eb2 = eb2; t.et2 = et2; t.ed2 = ed2;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rdy_in = t.rdy; flush_in = t.fl;
    bus.rename_en = t.ren; bus.rename_reg = t.rreg; bus.rename_index = t.ridx;
    bus.commit_en = t.cen; bus.commit_reg = t.creg; bus.commit_index = t.cidx;
    bus.commit_data = t.cdata;
    bus.query_rs1 = t.q1; bus.query_rs2 = t.q2;
  endtask

  // Lookup results are checked before the edge that applies the vector;
  // tag is only meaningful (and checked) when busy is expected.
  task automatic check_vec(input int i, input vec_t t);
    chk($sformatf("v%0d rs1_busy", i), 32'(bus.rs1_busy), 32'(t.eb1));
    chk($sformatf("v%0d rs1_data", i), bus.rs1_data, t.ed1);
    if (t.eb1) chk($sformatf("v%0d rs1_tag", i), 32'(bus.rs1_tag), 32'(t.et1));
    chk($sformatf("v%0d rs2_busy", i), 32'(bus.rs2_busy), 32'(t.eb2));
    chk($sformatf("v%0d rs2_data", i), bus.rs2_data, t.ed2);
    if (t.eb2) chk($sformatf("v%0d rs2_tag", i), 32'(bus.rs2_tag), 32'(t.et2));
  endtask

  vec_t tbl[$];

  initial begin
    //            rdy fl ren rreg ridx cen creg cidx cdata          q1 b t d              q2 b t d
    tbl.push_back(v(1, 0, 0, 5'd0, 3'd0, 1, 5'd0, 3'd0, 32'hDEADBEEF, 5'd0, 0,3'd0,32'h0,    5'd5, 0,3'd0,32'h0));
    tbl.push_back(v(1, 0, 1, 5'd5, 3'd3, 0, 5'd0, 3'd0, 32'h0,        5'd0, 0,3'd0,32'h0,    5'd5, 0,3'd0,32'h0));
    tbl.push_back(v(1, 0, 0, 5'd0, 3'd0, 1, 5'd5, 3'd3, 32'h1234,     5'd5, 0,3'd0,32'h1234, 5'd0, 0,3'd0,32'h0));
    tbl.push_back(v(1, 0, 1, 5'd7, 3'd2, 0, 5'd0, 3'd0, 32'h0,        5'd5, 0,3'd0,32'h1234, 5'd7, 0,3'd0,32'h0));
    tbl.push_back(v(1, 0, 1, 5'd7, 3'd5, 0, 5'd0, 3'd0, 32'h0,        5'd7, 1,3'd2,32'h0,    5'd5, 0,3'd0,32'h1234));
    // stale commit (idx 2) while x7 is mapped to tag 5: no bypass
    tbl.push_back(v(1, 0, 0, 5'd0, 3'd0, 1, 5'd7, 3'd2, 32'd9,        5'd7, 1,3'd5,32'h0,    5'd0, 0,3'd0,32'h0));
    tbl.push_back(v(1, 0, 1, 5'd0, 3'd7, 0, 5'd0, 3'd0, 32'h0,        5'd7, 1,3'd5,32'd9,    5'd5, 0,3'd0,32'h1234));
    tbl.push_back(v(1, 0, 0, 5'd0, 3'd0, 1, 5'd7, 3'd5, 32'd11,       5'd7, 0,3'd0,32'd11,   5'd0, 0,3'd0,32'h0));
    tbl.push_back(v(1, 0, 1, 5'd4, 3'd1, 0, 5'd0, 3'd0, 32'h0,        5'd7, 0,3'd0,32'd11,   5'd4, 0,3'd0,32'h0));
    // same-cycle rename x4->6 and commit x4 idx 1
    tbl.push_back(v(1, 0, 1, 5'd4, 3'd6, 1, 5'd4, 3'd1, 32'h55,       5'd4, 0,3'd0,32'h55,   5'd7, 0,3'd0,32'd11));
    tbl.push_back(v(1, 0, 0, 5'd0, 3'd0, 1, 5'd2, 3'd0, 32'hAA,       5'd4, 1,3'd6,32'h55,   5'd0, 0,3'd0,32'h0));
    tbl.push_back(v(1, 0, 0, 5'd0, 3'd0, 1, 5'd3, 3'd0, 32'hBB,       5'd2, 0,3'd0,32'hAA,   5'd0, 0,3'd0,32'h0));
    tbl.push_back(v(1, 0, 1, 5'd1, 3'd0, 0, 5'd0, 3'd0, 32'h0,        5'd3, 0,3'd0,32'hBB,   5'd1, 0,3'd0,32'h0));
    tbl.push_back(v(1, 0, 1, 5'd2, 3'd1, 0, 5'd0, 3'd0, 32'h0,        5'd1, 1,3'd0,32'h0,    5'd2, 0,3'd0,32'hAA));
    tbl.push_back(v(1, 0, 1, 5'd3, 3'd2, 0, 5'd0, 3'd0, 32'h0,        5'd2, 1,3'd1,32'hAA,   5'd0, 0,3'd0,32'h0));
    // flush + commit x1 idx 0 + rename x6 (discarded)
    tbl.push_back(v(1, 1, 1, 5'd6, 3'd4, 1, 5'd1, 3'd0, 32'd7,        5'd1, 0,3'd0,32'd7,    5'd3, 1,3'd2,32'hBB));
    tbl.push_back(v(1, 0, 0, 5'd0, 3'd0, 0, 5'd0, 3'd0, 32'h0,        5'd1, 0,3'd0,32'd7,    5'd2, 0,3'd0,32'hAA));
    tbl.push_back(v(1, 0, 0, 5'd0, 3'd0, 0, 5'd0, 3'd0, 32'h0,        5'd3, 0,3'd0,32'hBB,   5'd6, 0,3'd0,32'h0));
    tbl.push_back(v(1, 0, 0, 5'd0, 3'd0, 0, 5'd0, 3'd0, 32'h0,        5'd4, 0,3'd0,32'h55,   5'd7, 0,3'd0,32'd11));
    // rdy low: rename x8 and commit x4 must be ignored
    tbl.push_back(v(0, 0, 1, 5'd8, 3'd7, 1, 5'd4, 3'd6, 32'h99,       5'd8, 0,3'd0,32'h0,    5'd4, 0,3'd0,32'h55));
    tbl.push_back(v(0, 1, 0, 5'd0, 3'd0, 1, 5'd9, 3'd0, 32'h66,       5'd8, 0,3'd0,32'h0,    5'd4, 0,3'd0,32'h55));
    tbl.push_back(v(1, 0, 1, 5'd9, 3'd3, 1, 5'd10,3'd0, 32'h77,       5'd8, 0,3'd0,32'h0,    5'd9, 0,3'd0,32'h0));

    rst_in = 1'b0;
    drive(v(1,0,0,5'd0,3'd0,0,5'd0,3'd0,32'h0,5'd0,0,3'd0,32'h0,5'd0,0,3'd0,32'h0));
    @(negedge clk_in);
    for (int r = 0; r < 32; r++) begin
      bus.query_rs1 = 5'(r);
      bus.query_rs2 = 5'(31 - r);
      #1;
      chk($sformatf("reset x%0d busy", r), 32'(bus.rs1_busy), 32'd0);
      chk($sformatf("reset x%0d tag", r),  32'(bus.rs1_tag),  32'd0);
      chk($sformatf("reset x%0d data", r), bus.rs1_data,      32'd0);
      chk($sformatf("reset x%0d data2", 31 - r), bus.rs2_data, 32'd0);
    end
    rst_in = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk_in);
      drive(tbl[i]);
      #1;
      check_vec(i, tbl[i]);
    end

    // State left by the last vector: x9 busy tag 3, x10 = 0x77.
    @(negedge clk_in);
    drive(v(1,0,0,5'd0,3'd0,0,5'd0,3'd0,32'h0,5'd9,0,3'd0,32'h0,5'd10,0,3'd0,32'h0));
    #1;
    chk("pre-rst x9 busy",  32'(bus.rs1_busy), 32'd1);
    chk("pre-rst x9 tag",   32'(bus.rs1_tag),  32'd3);
    chk("pre-rst x10 data", bus.rs2_data,      32'h77);
    // Async reset mid-cycle: cleared well before the next rising edge.
    rst_in = 1'b0;
    #1;
    chk("async rst x9 busy",  32'(bus.rs1_busy), 32'd0);
    chk("async rst x9 tag",   32'(bus.rs1_tag),  32'd0);
    chk("async rst x10 data", bus.rs2_data,      32'd0);
    bus.query_rs2 = 5'd4;
    #1;
    chk("async rst x4 data", bus.rs2_data, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    #1;
    chk("post-rst x9 busy", 32'(bus.rs1_busy), 32'd0);
    chk("post-rst x4 data", bus.rs2_data,      32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_status_file.md
Name: register_status_file

Overview:
- Architectural register file (x0–x31) with per-register rename status.
- Sits directly downstream of the reorder buffer: it consumes the RoB commit stream (RF_update_en/reg/index/data) and retires values into architectural state.
- Also serves the dispatcher:
  - Operand lookup returns either a value or the RoB tag to wait on.
  - Rename write marks a destination register as pending on a new RoB entry.

Parameters:
- RoB_WIDTH, 3, width of RoB index/tag; must match the reorder buffer.
- REG_COUNT, 32, number of architectural registers (fixed 32; x0 hardwired zero).

Ports:
- clk_in  input  1  clock, all state on rising edge
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global ready; low = hold all state
- flush_in  input  1  mispredict flush from RoB; clears all rename status
- rename_en  input  1  dispatcher allocates rd to a new RoB entry this cycle
- rename_reg  input  5  destination register being renamed
- rename_index  input  RoB_WIDTH  RoB index producing rename_reg
- query_rs1  input  5  source register 1 lookup
- query_rs2  input  5  source register 2 lookup
- rs1_busy  output  1  rs1 value pending in RoB
- rs1_tag  output  RoB_WIDTH  RoB index producing rs1 (valid when rs1_busy)
- rs1_data  output  32  rs1 value (valid when !rs1_busy)
- rs2_busy, rs2_tag, rs2_data  output  1/RoB_WIDTH/32  same for rs2
- commit_en  input  1  RoB commit write (from RF_update_en)
- commit_reg  input  5  committed destination register
- commit_index  input  RoB_WIDTH  RoB index being committed
- commit_data  input  32  committed value

Behaviour:
- State per register: data[31:0], busy, tag[RoB_WIDTH-1:0].
- Reset (rst_in=0, asynchronous): all data=0, busy=0, tag=0. The query outputs are combinational, so all lookups read busy=0, tag=0, data=0 while in reset.
- rdy_in=0: no state change; query outputs remain combinational on current state.
- Query, combinational, zero latency:
  - Reg x0: busy=0, tag=0, data=0 always.
  - Otherwise, if busy[r]=1 and commit_en and commit_reg==r and commit_index==tag[r] in the same cycle: bypass, report busy=0, data=commit_data.
  - Otherwise report stored busy/tag/data.
  - Same-cycle rename does NOT affect query. The dispatcher queries sources before renaming rd, so "addi x5,x5,1" reads the old x5 mapping.
- Commit, clocked, rdy_in=1, commit_reg!=0:
  - data[commit_reg] <= commit_data.
  - busy cleared only if tag[commit_reg]==commit_index; an older commit must not clear a newer rename.
- Rename, clocked, rdy_in=1, rename_reg!=0, flush_in=0: busy[rename_reg] <= 1, tag[rename_reg] <= rename_index.
- Rename and commit to the same register in the same cycle: data is written by the commit; busy=1 and tag=rename_index come from the rename (rename wins).
- Writes to x0 (rename or commit) are ignored.
- flush_in=1 (with rdy_in=1):
  - All busy <= 0.
  - A commit in the same cycle still writes data; the committing instruction is older than the flush point.
  - A rename in the same cycle is discarded.
- Tag wrap-around: tags are compared for equality only. The RoB guarantees no two in-flight entries share an index.

Optional Feature:
- Macro: RF_DEBUG_PORT_EN.
- Defined: adds input debug_sel[4:0] and outputs debug_data[31:0] (combinational data[debug_sel], no bypass) and debug_commit_cnt[31:0].
  - debug_commit_cnt increments on every accepted commit with commit_reg!=0.
  - debug_commit_cnt resets to 0 and is not cleared by flush.
- Undefined: ports and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then query x0..x31 -> all busy=0, data=0; commit x0=0xDEADBEEF -> x0 still reads 0.
- Rename x5->tag 3, next cycle commit x5 idx 3 data 0x1234 -> in that commit cycle, query x5 shows busy=0, data=0x1234 (bypass); afterwards stored busy=0, data=0x1234.
- Rename x7->tag 2, rename x7->tag 5, commit x7 idx 2 data 9 -> data=9, busy=1, tag=5; commit idx 5 data 11 -> busy=0, data=11.
- Same cycle: rename x4->tag 6 and commit x4 idx 1 (tag was 1) data 0x55 -> data=0x55, busy=1, tag=6.
- Rename x1,x2,x3 (tags 0,1,2), then flush_in with commit x1 idx 0 data 7 -> all busy=0, x1=7, x2/x3 keep old data; rename in the flush cycle is not recorded.
- rdy_in=0 during rename/commit pulses -> no state change; assert rst_in low mid-sequence -> state cleared immediately, without waiting for a clock edge.
